sipo_frame_ctrl: RTL and testbench
==================================

// Module: sipo_frame_ctrl
// PURPOSE
//  Sequencer for the N-bit serial-in/parallel-out shift path: frames a burst of N serial bits,
//  shifts them MSB-first into an internal SIPO core, then presents the word on a valid/ready port.
//  Sits between a bit-serial source (strobed by ser_valid) and any parallel word consumer.
//  Flags protocol violations (start while busy) via a sticky overrun bit.
// PARAMETERS
//  N      4            data bits per frame (N >= 2)
//  CNT_W  $clog2(N)    bit-counter width (derived; do not override)
// PORTS
//  clk       in   1   single clock, all logic on posedge
//  rst       in   1   asynchronous, active-low reset (0 = reset asserted)
//  start     in   1   frame start request, 1-cycle pulse
//  abort     in   1   discard a frame in progress
//  ser_in    in   1   serial data bit
//  ser_valid in   1   ser_in qualifier; a bit is consumed only when ser_valid=1 in SHIFT/PAR
//  out_ready in   1   consumer accepts out_data
//  out_data  out  N   assembled word; first bit received lands in out_data[N-1]
//  out_valid out  1   out_data valid; held until out_ready
//  busy      out  1   1 in SHIFT/PAR/HOLD
//  overrun   out  1   sticky: start seen while busy and not accepted
//  clr_ovr   in   1   synchronous clear of overrun
//  par_err   out  1   parity error, qualified by out_valid (tied 0 without the macro)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, shift reg=0, cnt=0, out_data=0, out_valid=0, busy=0,
//   overrun=0, par_err=0. Reset mid-frame discards all partial data immediately.
//  States: IDLE, SHIFT, PAR (macro only), HOLD.
//  IDLE: start=1 -> SHIFT, cnt<=0, shift reg<=0. ser_valid in the start cycle is ignored.
//  SHIFT: on ser_valid: sr<={sr[N-2:0],ser_in}, cnt<=cnt+1. Cycles with ser_valid=0 are holes.
//   On ser_valid with cnt==N-1: out_data<={sr[N-2:0],ser_in}, out_valid<=1, -> HOLD
//   (-> PAR with macro). out_valid rises the cycle after the last bit is sampled.
//  HOLD: out_data/out_valid stable until out_valid&out_ready; then out_valid<=0 -> IDLE.
//   out_ready with start in the same cycle: word accepted AND start taken -> SHIFT directly,
//   no overrun (back-to-back frames).
//  start while busy and not the accept case above: ignored, overrun<=1 (sticky).
//  clr_ovr has priority over a same-cycle set (clear wins).
//  abort in SHIFT/PAR: -> IDLE, cnt<=0, no out_valid; abort in HOLD/IDLE ignored.
//  abort and start in the same cycle in SHIFT: abort wins, start ignored, no overrun.
//  ser_valid in IDLE/HOLD ignored. Counter never wraps: it is reset on each start.
//  out_ready with out_valid=0 has no effect.
// CONFIGURATION
//  PARITY_CHECK_EN defined: after the Nth data bit -> PAR; next ser_valid bit is the parity
//   bit; par_err<=^{data,parity} (even parity), out_valid<=1, -> HOLD. abort valid in PAR.
//  Not defined: no PAR state; HOLD entered after the Nth bit; par_err constant 0.
// STRUCTURE
//  sipo_ctrl_pkg: typedef enum state_t {IDLE,SHIFT,PAR,HOLD}; state encoding width;
//   localparam PARITY_EVEN=1'b0.
//  Sub-module sipo_shift_core #(N): shift register with shift_en/clear, async active-low rst.
//  Top holds FSM, counter, output register, overrun/parity logic.
// TESTING (N=4)
//  1 start, then bits 1,1,0,1 on 4 consecutive ser_valid -> out_valid=1 next cycle, out_data=4'b1101.
//  2 start, bits 1,0 then rst=0 -> out_valid=0, busy=0, out_data=0 at once; new frame 0011 -> 0011.
//  3 frame 1010 with ser_valid low 2 cycles between bits -> out_data=4'b1010, same final latency.
//  4 out_ready low 5 cycles, start in cycle 3 -> data held at 1101, overrun=1; clr_ovr -> overrun=0.
//  5 HOLD with out_ready=1 and start same cycle -> overrun=0, busy stays 1, next frame 0110 -> 0110.
//  6 PARITY_CHECK_EN: 1101+parity 1 -> par_err=0; 1101+parity 0 -> par_err=1; abort in PAR -> IDLE.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// Shared types and constants for the SIPO frame sequencer.
// Optional parity state is enabled with the PARITY_CHECK_EN macro.
package sipo_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;

  function automatic logic is_busy(input state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// MSB-first serial-in/parallel-out shift register with synchronous clear.
module sipo_shift_core #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         shift_en_i,
  input  logic         ser_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clear_i) begin
      q_q <= '0;
    end else if (shift_en_i) begin
      q_q <= {q_q[N-2:0], ser_i};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer: counts N serial bits into the shift core and presents the word
// on a valid/ready port. Define PARITY_CHECK_EN to add a trailing even-parity bit.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         ser_in,
  input  logic         ser_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun,
  input  logic         clr_ovr,
  output logic         par_err
);

  localparam int CNT_W = $clog2(N);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     out_data_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             overrun_q;
  logic [N-1:0]     sr;

  logic accept;
  logic take_start;
  logic shift_en;
  logic last_bit;
  logic ovr_set;

  always_comb begin
    accept     = (state_q == HOLD) && out_valid_q && out_ready;
    take_start = start && ((state_q == IDLE) || accept);
    shift_en   = (state_q == SHIFT) && ser_valid && !abort;
    last_bit   = shift_en && (cnt_q == CNT_W'(N - 1));
    // An abort in SHIFT/PAR swallows a same-cycle start without flagging it.
    ovr_set    = start && !take_start && is_busy(state_q)
                 && !(abort && ((state_q == SHIFT) || (state_q == PAR)));
  end

  sipo_shift_core #(.N(N)) u_core (
    .clk        (clk),
    .rst_n      (rst),
    .clear_i    (take_start),
    .shift_en_i (shift_en),
    .ser_i      (ser_in),
    .q_o        (sr)
  );

`ifdef PARITY_CHECK_EN
  logic par_err_q;
`else
  logic sr_msb_unused;
  assign sr_msb_unused = sr[N-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      if (clr_ovr) begin
        overrun_q <= 1'b0;
      end else if (ovr_set) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
`ifdef PARITY_CHECK_EN
            par_err_q <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (ser_valid) begin
            if (last_bit) begin
`ifdef PARITY_CHECK_EN
              state_q <= PAR;
`else
              out_data_q  <= {sr[N-2:0], ser_in};
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef PARITY_CHECK_EN
        PAR: begin
          if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (ser_valid) begin
            out_data_q  <= sr;
            par_err_q   <= (^{sr, ser_in}) != PARITY_EVEN;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
`endif
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (start) begin
              state_q <= SHIFT;
              cnt_q   <= '0;
`ifdef PARITY_CHECK_EN
              par_err_q <= 1'b0;
`endif
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl with N=4.
// Parity scenarios run only when PARITY_CHECK_EN is defined.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, ser_in, ser_valid, out_ready, clr_ovr;
  logic [3:0] out_data;
  logic       out_valid, busy, overrun, par_err;

  int checks   = 0;
  int failures = 0;

  sipo_frame_ctrl #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic data_bits(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) bit_in(w[i]);
`ifdef PARITY_CHECK_EN
    bit_in(^w);
`endif
  endtask

  task automatic accept_word();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; ser_in = 1'b0;
    ser_valid = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_overrun",   32'(overrun),   32'h0);
    chk("rst_par_err",   32'(par_err),   32'h0);
    rst = 1'b1;
    tick();

    // 1: consecutive bits 1101
    ser_valid = 1'b1; ser_in = 1'b1;  // ignored in start cycle
    start_frame();
    ser_valid = 1'b0;
    chk("t1_busy_after_start", 32'(busy), 32'h1);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    chk("t1_not_valid_early", 32'(out_valid), 32'h0);
    bit_in(1'b1);
`ifdef PARITY_CHECK_EN
    chk("t1_in_par_no_valid", 32'(out_valid), 32'h0);
    bit_in(1'b1);
`endif
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out_data",  32'(out_data),  32'hD);
    chk("t1_par_err",   32'(par_err),   32'h0);
    accept_word();
    chk("t1_valid_drop", 32'(out_valid), 32'h0);
    chk("t1_idle",       32'(busy),      32'h0);

    // out_ready with nothing valid has no effect
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("idle_ready_busy", 32'(busy), 32'h0);

    // 2: reset mid-frame, then a clean frame
    start_frame();
    bit_in(1'b1); bit_in(1'b0);
    rst = 1'b0;
    #1;
    chk("t2_rst_valid", 32'(out_valid), 32'h0);
    chk("t2_rst_busy",  32'(busy),      32'h0);
    chk("t2_rst_data",  32'(out_data),  32'h0);
    tick();
    rst = 1'b1;
    tick();
    start_frame();
    data_bits(4'b0011);
    chk("t2_valid", 32'(out_valid), 32'h1);
    chk("t2_data",  32'(out_data),  32'h3);
    accept_word();

    // 3: holes between bits
    start_frame();
    bit_in(1'b1); tick(); tick();
    bit_in(1'b0); tick(); tick();
    bit_in(1'b1); tick(); tick();
    chk("t3_not_valid_hole", 32'(out_valid), 32'h0);
    chk("t3_busy_hole",      32'(busy),      32'h1);
    bit_in(1'b0);
`ifdef PARITY_CHECK_EN
    bit_in(1'b0);
`endif
    chk("t3_valid", 32'(out_valid), 32'h1);
    chk("t3_data",  32'(out_data),  32'hA);
    accept_word();

    // 4: stalled consumer, start while holding
    start_frame();
    data_bits(4'b1101);
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_overrun_set", 32'(overrun), 32'h1);
    tick(); tick();
    chk("t4_data_held",  32'(out_data),  32'hD);
    chk("t4_valid_held", 32'(out_valid), 32'h1);
    chk("t4_busy",       32'(busy),      32'h1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    chk("t4_overrun_clr", 32'(overrun), 32'h0);
    clr_ovr = 1'b1; start = 1'b1; tick(); clr_ovr = 1'b0; start = 1'b0;
    chk("t4_clear_wins", 32'(overrun), 32'h0);
    chk("t4_still_valid", 32'(out_valid), 32'h1);

    // 5: accept and start in the same cycle
    out_ready = 1'b1; start = 1'b1; tick(); out_ready = 1'b0; start = 1'b0;
    chk("t5_no_overrun", 32'(overrun),   32'h0);
    chk("t5_busy",       32'(busy),      32'h1);
    chk("t5_valid_drop", 32'(out_valid), 32'h0);
    data_bits(4'b0110);
    chk("t5_valid", 32'(out_valid), 32'h1);
    chk("t5_data",  32'(out_data),  32'h6);
    accept_word();

    // abort mid-frame, then stray bits in IDLE, then a full frame
    start_frame();
    bit_in(1'b1); bit_in(1'b1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_busy",  32'(busy),      32'h0);
    chk("ab_valid", 32'(out_valid), 32'h0);
    bit_in(1'b1); bit_in(1'b1);
    chk("idle_bits_busy", 32'(busy), 32'h0);
    start_frame();
    data_bits(4'b1001);
    chk("ab_restart_data", 32'(out_data), 32'h9);
    accept_word();

    // abort and start together in SHIFT; then start in SHIFT alone
    start_frame();
    bit_in(1'b0);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("abst_busy",    32'(busy),    32'h0);
    chk("abst_overrun", 32'(overrun), 32'h0);
    start_frame();
    bit_in(1'b1);
    start = 1'b1; tick(); start = 1'b0;
    chk("shift_start_ovr", 32'(overrun), 32'h1);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
`ifdef PARITY_CHECK_EN
    bit_in(1'b1);
`endif
    chk("shift_start_data", 32'(out_data), 32'hB);
    accept_word();
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;

`ifdef PARITY_CHECK_EN
    // 6: parity outcomes and abort in PAR
    start_frame();
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    bit_in(1'b1);
    chk("t6_good_valid", 32'(out_valid), 32'h1);
    chk("t6_good_perr",  32'(par_err),   32'h0);
    accept_word();
    start_frame();
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    bit_in(1'b0);
    chk("t6_bad_perr", 32'(par_err),  32'h1);
    chk("t6_bad_data", 32'(out_data), 32'hD);
    accept_word();
    start_frame();
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t6_par_abort_busy",  32'(busy),      32'h0);
    chk("t6_par_abort_valid", 32'(out_valid), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
